// File: rtl/data_bus_bridge.sv
// rtl/data_bus_bridge.sv - CPU data-side bus: word RAM, LED, cycle counter, TX byte FIFO
// Reads are combinational so the MEM-stage forwarding path sees data in the same cycle.
module data_bus_bridge #(
  parameter int RAM_AW  = 10,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic        data_we,
  input  logic [31:0] data_write,
  output logic [31:0] data_mem,
  output logic [15:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam int DEPTH     = 1 << FIFO_AW;

  localparam logic [31:0] ADDR_LED    = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0008;
  localparam logic [31:0] ADDR_TXSTAT = 32'hFFFF_000C;

  localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

  // Byte offset bits are masked off here so every decode works on word addresses.
  logic [31:0] word_addr;
  assign word_addr = data_addr & 32'hFFFF_FFFC;

  logic ram_sel, led_sel, cycle_sel, txdata_sel, txstat_sel;
  assign ram_sel    = (word_addr[31:RAM_AW+2] == '0);
  assign led_sel    = (word_addr == ADDR_LED);
  assign cycle_sel  = (word_addr == ADDR_CYCLE);
  assign txdata_sel = (word_addr == ADDR_TXDATA);
  assign txstat_sel = (word_addr == ADDR_TXSTAT);

  logic [RAM_AW-1:0] ram_idx;
  assign ram_idx = word_addr[RAM_AW+1:2];

  logic [31:0] ram [0:RAM_WORDS-1];

  always_ff @(posedge clk) begin
    if (data_we && ram_sel) begin
      ram[ram_idx] <= data_write;
    end
  end

  logic [31:0]        cycle_cnt;
  logic [7:0]         fifo_mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW:0]   count;
  logic               overflow;

  logic fifo_empty, fifo_full, pop, push, push_drop;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == COUNT_FULL);
  assign pop        = tx_valid && tx_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the byte.
  assign push       = data_we && txdata_sel && (!fifo_full || pop);
  assign push_drop  = data_we && txdata_sel && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= data_write[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led       <= 16'h0000;
      cycle_cnt <= 32'h0000_0000;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      if (data_we && led_sel) begin
        led <= data_write[15:0];
      end

      if (data_we && cycle_sel) begin
        cycle_cnt <= data_write;
      end else begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A drop in the same cycle as a status write keeps the flag set.
      if (push_drop) begin
        overflow <= 1'b1;
      end else if (data_we && txstat_sel) begin
        overflow <= 1'b0;
      end
    end
  end

  assign tx_valid = !fifo_empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  logic [31:0] txstat_word;
  assign txstat_word = {{(32 - FIFO_AW - 5){1'b0}}, count, 1'b0, overflow, fifo_empty, fifo_full};

  always_comb begin
    data_mem = 32'h0000_0000;
    if (ram_sel) begin
      data_mem = ram[ram_idx];
    end else if (led_sel) begin
      data_mem = {16'h0000, led};
    end else if (cycle_sel) begin
      data_mem = cycle_cnt;
    end else if (txstat_sel) begin
      data_mem = txstat_word;
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// tb/tb_data_bus_bridge.sv - self-checking bench for data_bus_bridge
// Queue/associative-array reference model, directed scenarios plus randomized traffic.
module tb_data_bus_bridge;

  localparam int RAM_AW    = 10;
  localparam int FIFO_AW   = 3;
  localparam int DEPTH     = 8;
  localparam int RAM_BYTES = 4096;

  localparam logic [31:0] A_LED = 32'hFFFF_0000;
  localparam logic [31:0] A_CYC = 32'hFFFF_0004;
  localparam logic [31:0] A_TXD = 32'hFFFF_0008;
  localparam logic [31:0] A_TXS = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic        data_we;
  logic [31:0] data_write;
  logic [31:0] data_mem;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mram [int];
  logic [15:0] mled;
  logic [31:0] mcyc;
  logic [7:0]  mfifo [$];
  bit          movf;

  always #5 clk = ~clk;

  data_bus_bridge #(.RAM_AW(RAM_AW), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst(rst), .data_addr(data_addr), .data_we(data_we),
    .data_write(data_write), .data_mem(data_mem), .led(led),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  task automatic model_clear();
    mled = 16'h0;
    mcyc = 32'h0;
    mfifo.delete();
    movf = 1'b0;
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] wd);
    data_addr  = a;
    data_we    = we;
    data_write = wd;
    #1;
  endtask

  // Advances one clock and applies the same access to the reference model.
  task automatic tick();
    logic [31:0] a, wd;
    logic we;
    bit pop, push, drop;
    int sz;
    a    = data_addr & 32'hFFFF_FFFC;
    we   = data_we;
    wd   = data_write;
    sz   = mfifo.size();
    pop  = (sz > 0) && tx_ready;
    push = we && (a == A_TXD) && ((sz < DEPTH) || pop);
    drop = we && (a == A_TXD) && (sz == DEPTH) && !pop;
    @(posedge clk);
    #1;
    if (pop) void'(mfifo.pop_front());
    if (push) mfifo.push_back(wd[7:0]);
    if (we && a < RAM_BYTES) mram[int'(a >> 2)] = wd;
    if (we && a == A_LED) mled = wd[15:0];
    if (we && a == A_CYC) mcyc = wd;
    else mcyc = mcyc + 32'd1;
    if (we && a == A_TXS) movf = 1'b0;
    if (drop) movf = 1'b1;
  endtask

  function automatic bit model_read(input logic [31:0] addr, output logic [31:0] val);
    logic [31:0] a;
    int sz;
    a   = addr & 32'hFFFF_FFFC;
    sz  = mfifo.size();
    val = 32'h0;
    if (a < RAM_BYTES) begin
      if (!mram.exists(int'(a >> 2))) return 1'b0;
      val = mram[int'(a >> 2)];
    end else if (a == A_LED) val = {16'h0, mled};
    else if (a == A_CYC) val = mcyc;
    else if (a == A_TXS) val = 32'(sz * 16 + (movf ? 4 : 0) + (sz == 0 ? 2 : 0) + (sz == DEPTH ? 1 : 0));
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; tx_ready = 1'b0;
    data_addr = 32'h0; data_we = 1'b0; data_write = 32'h0;
    #12;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    drive(A_TXS, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h2) begin failures++; $display("FAIL reset_txstat got=%h exp=%h", data_mem, 32'h2); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=0", led); end
    checks++; if (tx_data !== 8'h0) begin failures++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
    for (int i = 0; i < 4; i++) begin
      drive(A_CYC, 1'b0, 32'h0);
      checks++; if (data_mem !== 32'(i)) begin failures++; $display("FAIL reset_cycle%0d got=%h exp=%h", i, data_mem, 32'(i)); end
      tick();
    end
  endtask

  task automatic test_ram();
    drive(32'h10, 1'b1, 32'hDEAD_BEEF); tick();
    drive(32'h10, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_raw10 got=%h exp=deadbeef", data_mem); end
    drive(32'h14, 1'b1, 32'h1); tick();
    drive(32'h14, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h1) begin failures++; $display("FAIL ram_raw14 got=%h exp=1", data_mem); end
    drive(32'h13, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_lowbits got=%h exp=deadbeef", data_mem); end
    drive(32'h1234_5678, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", data_mem); end
    drive(32'h0, 1'b1, 32'h1111_1111); tick();
    drive(32'h1000, 1'b1, 32'h5555_5555); tick();
    drive(32'h0, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h1111_1111) begin failures++; $display("FAIL ram_no_alias got=%h exp=11111111", data_mem); end
    drive(32'h1000, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h0) begin failures++; $display("FAIL ram_above_top got=%h exp=0", data_mem); end
    drive(32'hFFC, 1'b1, 32'hCAFE_F00D); tick();
    drive(32'hFFC, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'hCAFE_F00D) begin failures++; $display("FAIL ram_top_word got=%h exp=cafef00d", data_mem); end
    drive(A_TXD, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h0) begin failures++; $display("FAIL txdata_read got=%h exp=0", data_mem); end
  endtask

  task automatic test_led_cycle();
    drive(A_LED, 1'b1, 32'h0001_ABCD); tick();
    checks++; if (led !== 16'hABCD) begin failures++; $display("FAIL led_port got=%h exp=abcd", led); end
    drive(A_LED, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h0000_ABCD) begin failures++; $display("FAIL led_read got=%h exp=0000abcd", data_mem); end
    drive(A_CYC, 1'b1, 32'h100); tick();
    drive(A_CYC, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h100) begin failures++; $display("FAIL cycle_load got=%h exp=100", data_mem); end
    tick();
    checks++; if (data_mem !== 32'h101) begin failures++; $display("FAIL cycle_incr got=%h exp=101", data_mem); end
  endtask

  task automatic test_fifo_overflow();
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      drive(A_TXD, 1'b1, 32'(i)); tick();
    end
    drive(A_TXS, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h85) begin failures++; $display("FAIL ovf_txstat got=%h exp=85", data_mem); end
    tx_ready = 1'b1; #1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        failures++; $display("FAIL ovf_stream%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'(i));
      end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained_valid got=%b exp=0", tx_valid); end
    drive(A_TXS, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h06) begin failures++; $display("FAIL ovf_sticky got=%h exp=06", data_mem); end
    tx_ready = 1'b0;
    drive(A_TXS, 1'b1, 32'h0); tick();
    drive(A_TXS, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h02) begin failures++; $display("FAIL ovf_clear got=%h exp=02", data_mem); end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] exp_b;
    tx_ready = 1'b0;
    drive(A_TXD, 1'b1, 32'h10);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL no_bypass got=%b exp=0", tx_valid); end
    tick();
    for (int i = 1; i < 8; i++) begin
      drive(A_TXD, 1'b1, 32'h10 + 32'(i)); tick();
    end
    drive(A_TXS, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h81) begin failures++; $display("FAIL full_txstat got=%h exp=81", data_mem); end
    tx_ready = 1'b1;
    drive(A_TXD, 1'b1, 32'hFFFF_FFAA);
    checks++; if (tx_data !== 8'h10) begin failures++; $display("FAIL full_head got=%h exp=10", tx_data); end
    tick();
    tx_ready = 1'b0;
    drive(A_TXS, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h81) begin failures++; $display("FAIL full_pop_push got=%h exp=81", data_mem); end
    tx_ready = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      exp_b = (i == 7) ? 8'hAA : 8'h11 + 8'(i);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
        failures++; $display("FAIL full_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b);
      end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, wd, exp_v;
    logic we;
    int sel, idx;
    for (int n = 0; n < 400; n++) begin
      tx_ready = ($urandom_range(0, 3) < ((n < 200) ? 1 : 3));
      sel = $urandom_range(0, 9);
      wd  = $urandom;
      we  = 1'b0;
      idx = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 15);
      case (sel)
        0, 1: begin a = 32'(idx * 4); we = 1'b1; end
        2:    begin a = 32'(idx * 4); we = !mram.exists(idx); end
        3:    begin a = A_LED; we = $urandom_range(0, 1); end
        4:    begin a = A_CYC; we = ($urandom_range(0, 3) == 0); end
        5, 6: begin a = A_TXD; we = 1'b1; end
        7:    begin a = A_TXS; we = ($urandom_range(0, 3) == 0); end
        8: begin
          a = 32'h8000_0000 | $urandom;
          if (a[31:4] == 28'hFFFF000) a = 32'hFFFF_0020;
          we = $urandom_range(0, 1);
        end
        default: a = A_TXD;
      endcase
      a = a | 32'($urandom_range(0, 3));
      drive(a, we, wd);
      if (model_read(a, exp_v)) begin
        checks++; if (data_mem !== exp_v) begin failures++; $display("FAIL rnd_read n=%0d addr=%h got=%h exp=%h", n, a, data_mem, exp_v); end
      end
      checks++; if (tx_valid !== (mfifo.size() > 0)) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, tx_valid, mfifo.size() > 0); end
      if (mfifo.size() > 0) begin
        checks++; if (tx_data !== mfifo[0]) begin failures++; $display("FAIL rnd_tx_data n=%0d got=%h exp=%h", n, tx_data, mfifo[0]); end
      end
      checks++; if (led !== mled) begin failures++; $display("FAIL rnd_led n=%0d got=%h exp=%h", n, led, mled); end
      tick();
    end
    tx_ready = 1'b0;
    data_we  = 1'b0;
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    drive(A_TXS, 1'b1, 32'h0); tick();
    while (mfifo.size() > 0) begin
      tx_ready = 1'b1; drive(A_TXD, 1'b0, 32'h0); tick();
    end
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(A_TXD, 1'b1, 32'h30 + 32'(i)); tick();
    end
    drive(A_LED, 1'b1, 32'h5); tick();
    drive(A_TXS, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h30 || led !== 16'h5) begin failures++; $display("FAIL pre_reset got=%h/%h exp=30/5", data_mem, led); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", tx_valid); end
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL async_rst_led got=%h exp=0", led); end
    data_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    drive(A_TXS, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h2) begin failures++; $display("FAIL post_rst_txstat got=%h exp=2", data_mem); end
    drive(A_CYC, 1'b0, 32'h0);
    checks++; if (data_mem !== 32'h0) begin failures++; $display("FAIL post_rst_cycle got=%h exp=0", data_mem); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led_cycle();
    test_fifo_overflow();
    test_full_pop_push();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
